// File: rtl/mac_stream_accum_if.sv
// mac_stream_accum_if: operand-beat and result handshake bundle for the frame MAC.
// The slave modport faces the accumulator; the master modport faces producer and consumer.
interface mac_stream_accum_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [CNT_W-1:0]  len;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  modport slave (
    input  in_valid, a, b, len, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

  modport master (
    output in_valid, a, b, len, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/mac_stream_accum.sv
// mac_stream_accum: pipelined frame multiply-accumulate with a held, backpressured result register.
// Optional feature macro MAC_SAT_EN: clamp the frame sum at all-ones on overflow instead of wrapping.
module mac_stream_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  mac_stream_accum_if.slave bus,
  output logic              busy
);

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("mac_stream_accum: ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    len_q;

  logic                s1_valid_q;
  logic                s1_first_q;
  logic                s1_last_q;
  logic [ACC_W-1:0]    s1_prod_q;

  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q;

  logic                pend_q;
  logic [ACC_W-1:0]    fin_acc_q;
  logic                fin_ovf_q;

  logic                out_valid_q;
  logic [ACC_W-1:0]    out_acc_q;
  logic                out_ovf_q;

  logic                stall;
  logic                in_ready;
  logic                accept;
  logic [CNT_W-1:0]    len_eff;
  logic [CNT_W-1:0]    cnt_inc;
  logic                first_d;
  logic                last_d;
  logic [2*DATA_W-1:0] mult;
  logic [ACC_W-1:0]    prod;
  logic [ACC_W-1:0]    base;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_d;
  logic                ovf_d;

  assign stall    = out_valid_q & ~bus.out_ready;
  assign in_ready = ~stall & ~clear & ~reset;
  assign accept   = bus.in_valid & in_ready;

  assign len_eff  = (bus.len == '0) ? CNT_W'(1) : bus.len;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign mult     = (2*DATA_W)'(bus.a) * (2*DATA_W)'(bus.b);
  assign prod     = ACC_W'(mult);

  // A beat opening a frame takes its length from the bus; later beats compare against the latched one.
  always_comb begin
    first_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        first_d = 1'b1;
        last_d  = (len_eff == CNT_W'(1));
      end
      ACCUM: begin
        last_d  = (cnt_inc == len_q);
      end
      default: begin
        first_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // The first beat of a frame ignores the stale sum and overflow flag so frames can run back to back.
  always_comb begin
    base  = s1_first_q ? '0 : acc_q;
    sum   = {1'b0, base} + {1'b0, s1_prod_q};
    ovf_d = sum[ACC_W] | (~s1_first_q & ovf_q);
`ifdef MAC_SAT_EN
    acc_d = ovf_d ? '1 : sum[ACC_W-1:0];
`else
    acc_d = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      fin_acc_q   <= '0;
      fin_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_prod_q  <= prod;
        s1_first_q <= first_d;
        s1_last_q  <= last_d;
        if (last_d) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (state_q == IDLE) begin
          state_q <= ACCUM;
          cnt_q   <= CNT_W'(1);
          len_q   <= len_eff;
        end else begin
          cnt_q   <= cnt_inc;
        end
      end

      // Final sums park in fin_* for one cycle so the accumulator is free for the next frame.
      pend_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          fin_acc_q <= acc_d;
          fin_ovf_q <= ovf_d;
          acc_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          acc_q     <= acc_d;
          ovf_q     <= ovf_d;
        end
      end

      out_valid_q <= pend_q;
      if (pend_q) begin
        out_acc_q <= fin_acc_q;
        out_ovf_q <= fin_ovf_q;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;
  assign busy          = (state_q == ACCUM) | s1_valid_q | pend_q;

endmodule

// File: tb/tb_mac_stream_accum.sv
// tb_mac_stream_accum: drives one stimulus stream into a 40-bit and a 32-bit accumulator instance
// and scores every consumed result against a frame-level arithmetic model.
module tb_mac_stream_accum;

`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  len;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        inValid;
  logic        outReady;
  logic [15:0] inA;
  logic [15:0] inB;
  logic [7:0]  inLen;
  logic        busy40;
  logic        busy32;

  int compareCount  = 0;
  int mismatchCount = 0;

  beat_t             beatQ[$];
  longint unsigned   exp40Acc[$];
  bit                exp40Ovf[$];
  longint unsigned   exp32Acc[$];
  bit                exp32Ovf[$];
  bit                frameOpen = 1'b0;
  int                frameLen  = 0;
  int                frameCnt  = 0;
  longint unsigned   frameSum  = 0;
  logic              preInReady;

  always #5 clk = ~clk;

  mac_stream_accum_if #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) bus40 ();
  mac_stream_accum_if #(.DATA_W(16), .ACC_W(32), .CNT_W(8)) bus32 ();

  assign bus40.in_valid  = inValid;
  assign bus40.a         = inA;
  assign bus40.b         = inB;
  assign bus40.len       = inLen;
  assign bus40.out_ready = outReady;
  assign bus32.in_valid  = inValid;
  assign bus32.a         = inA;
  assign bus32.b         = inB;
  assign bus32.len       = inLen;
  assign bus32.out_ready = outReady;

  mac_stream_accum #(.DATA_W(16), .ACC_W(40), .CNT_W(8)) dut40 (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus40),
    .busy  (busy40)
  );

  mac_stream_accum #(.DATA_W(16), .ACC_W(32), .CNT_W(8)) dut32 (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus32),
    .busy  (busy32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, actual, expected);
    end
  endtask

  // A frame's true sum overflows a W-bit accumulator exactly when it reaches 2^W.
  function automatic longint unsigned frameResult(input longint unsigned s, input int w);
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    if ((s >> w) != 0) return SAT ? mask : (s & mask);
    return s;
  endfunction

  function automatic void modelBeat(input beat_t bt);
    if (!frameOpen) begin
      frameOpen = 1'b1;
      frameLen  = (bt.len == 8'd0) ? 1 : int'(bt.len);
      frameCnt  = 0;
      frameSum  = 0;
    end
    frameSum += 64'(bt.a) * 64'(bt.b);
    frameCnt++;
    if (frameCnt == frameLen) begin
      exp40Acc.push_back(frameResult(frameSum, 40));
      exp40Ovf.push_back((frameSum >> 40) != 0);
      exp32Acc.push_back(frameResult(frameSum, 32));
      exp32Ovf.push_back((frameSum >> 32) != 0);
      frameOpen = 1'b0;
    end
  endfunction

  function automatic void modelFlush();
    frameOpen = 1'b0;
    exp40Acc.delete();
    exp40Ovf.delete();
    exp32Acc.delete();
    exp32Ovf.delete();
  endfunction

  task automatic pushBeat(input int a, input int b, input int len);
    beat_t bt;
    bt.a   = 16'(a);
    bt.b   = 16'(b);
    bt.len = 8'(len);
    beatQ.push_back(bt);
  endtask

  // One clock: drive at negedge, score the handshakes the coming edge will see, return just after it.
  task automatic applyStimulus(input bit clr, input bit rst, input bit ordy, input bit allowGaps);
    bit iv;
    iv = (beatQ.size() > 0) && (!allowGaps || $urandom_range(0, 3) != 0);
    @(negedge clk);
    inValid  = iv;
    inA      = iv ? beatQ[0].a   : 16'($urandom);
    inB      = iv ? beatQ[0].b   : 16'($urandom);
    inLen    = iv ? beatQ[0].len : 8'($urandom);
    clear    = clr;
    reset    = rst;
    outReady = ordy;
    #1;
    preInReady = bus40.in_ready;
    if (clr || rst) begin
      checkOutput("inReadyAbort", 64'(bus40.in_ready), 64'd0);
      modelFlush();
    end else begin
      if (bus40.out_valid && ordy) begin
        if (exp40Acc.size() == 0) checkOutput("spurious40", 64'd1, 64'd0);
        else begin
          checkOutput("acc40", 64'(bus40.out_acc), exp40Acc.pop_front());
          checkOutput("ovf40", 64'(bus40.out_ovf), 64'(exp40Ovf.pop_front()));
        end
      end
      if (bus32.out_valid && ordy) begin
        if (exp32Acc.size() == 0) checkOutput("spurious32", 64'd1, 64'd0);
        else begin
          checkOutput("acc32", 64'(bus32.out_acc), exp32Acc.pop_front());
          checkOutput("ovf32", 64'(bus32.out_ovf), 64'(exp32Ovf.pop_front()));
        end
      end
      if (iv && bus40.in_ready) modelBeat(beatQ.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid(input string tag, input int maxCycles);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end while (!bus40.out_valid && n < maxCycles);
    if (!bus40.out_valid) checkOutput({tag, "Timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    inA      = '0;
    inB      = '0;
    inLen    = '0;

    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rstOutValid", 64'(bus40.out_valid), 64'd0);
    checkOutput("rstOutAcc",   64'(bus40.out_acc),   64'd0);
    checkOutput("rstOutOvf",   64'(bus40.out_ovf),   64'd0);
    checkOutput("rstBusy",     64'(busy40),          64'd0);

    $display("[TB] single-product frame");
    pushBeat(10, 20, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat0Valid", 64'(bus40.out_valid), 64'd0);
    checkOutput("lat0Busy",  64'(busy40),          64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat1Valid", 64'(bus40.out_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat2Valid", 64'(bus40.out_valid), 64'd1);
    checkOutput("singleAcc", 64'(bus40.out_acc),   64'd200);
    checkOutput("singleOvf", 64'(bus40.out_ovf),   64'd0);

    $display("[TB] back-to-back frames");
    pushBeat(1, 2, 4); pushBeat(3, 4, 0); pushBeat(5, 6, 9); pushBeat(7, 8, 1);
    pushBeat(10, 20, 2); pushBeat(2, 3, 7);
    waitOutValid("b2bFirst", 20);
    checkOutput("b2bFirstAcc", 64'(bus40.out_acc), 64'd100);
    waitOutValid("b2bSecond", 20);
    checkOutput("b2bSecondAcc", 64'(bus40.out_acc), 64'd206);

    $display("[TB] backpressure");
    pushBeat(1, 2, 4); pushBeat(3, 4, 0); pushBeat(5, 6, 0); pushBeat(7, 8, 0);
    pushBeat(10, 20, 2); pushBeat(2, 3, 0); pushBeat(3, 3, 1);
    waitOutValid("bp", 20);
    checkOutput("bpAcc", 64'(bus40.out_acc), 64'd100);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bpInReady", 64'(preInReady),      64'd0);
      checkOutput("bpHold",    64'(bus40.out_acc),   64'd100);
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] overflow");
    pushBeat(65535, 65535, 2); pushBeat(65535, 65535, 0);
    waitOutValid("ovf", 20);
    checkOutput("ovfAcc32", 64'(bus32.out_acc), SAT ? 64'd4294967295 : 64'd4294705154);
    checkOutput("ovfFlag32", 64'(bus32.out_ovf), 64'd1);
    checkOutput("ovfAcc40", 64'(bus40.out_acc), 64'd8589672450);
    checkOutput("ovfFlag40", 64'(bus40.out_ovf), 64'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] clear mid-frame");
    pushBeat(1, 1, 4); pushBeat(2, 2, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    pushBeat(7, 7, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clrBusy",  64'(busy40),          64'd0);
    checkOutput("clrValid", 64'(bus40.out_valid), 64'd0);
    pushBeat(3, 3, 1);
    waitOutValid("clrA", 20);
    checkOutput("clrAcc49", 64'(bus40.out_acc), 64'd49);
    waitOutValid("clrB", 20);
    checkOutput("clrAcc9", 64'(bus40.out_acc), 64'd9);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset with held output");
    pushBeat(5, 5, 1); pushBeat(1, 2, 3); pushBeat(1, 2, 0); pushBeat(1, 2, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("heldValid", 64'(bus40.out_valid), 64'd1);
    checkOutput("heldBusy",  64'(busy40),          64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("midRstValid", 64'(bus40.out_valid), 64'd0);
    checkOutput("midRstAcc",   64'(bus40.out_acc),   64'd0);
    checkOutput("midRstOvf",   64'(bus40.out_ovf),   64'd0);
    checkOutput("midRstBusy",  64'(busy40),          64'd0);
    pushBeat(4, 4, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("postRstInReady", 64'(preInReady), 64'd1);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 150; f++) begin
      int frameBeats;
      int lenField;
      lenField   = $urandom_range(0, 9);
      frameBeats = (lenField == 0) ? 1 : lenField;
      for (int k = 0; k < frameBeats; k++)
        pushBeat($urandom_range(0, 65535), $urandom_range(0, 65535),
                 (k == 0) ? lenField : $urandom_range(0, 15));
      while (beatQ.size() > 6)
        applyStimulus($urandom_range(0, 99) == 0, 1'b0, $urandom_range(0, 3) != 0, 1'b1);
    end
    for (int i = 0; i < 300 && (beatQ.size() > 0 || exp40Acc.size() > 0 || bus40.out_valid); i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain40", 64'(exp40Acc.size()), 64'd0);
    checkOutput("drain32", 64'(exp32Acc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mac_stream_accum.md
# mac_stream_accum

Parametrised, pipelined multiply-accumulate unit for the MAC datapath. It replaces the free-running accumulator with a frame-based one: it accepts a stream of operand pairs over a valid/ready handshake, sums `len` products per frame, and presents each frame's result on a held output register with backpressure. Intended as the accumulate stage behind the Vedic multiplier tree, generalised in operand and accumulator width, with overflow reporting.

## Interface
- `DATA_W`, default 16: operand width, unsigned.
- `ACC_W`, default 40: accumulator and result width. Must be ≥ 2·DATA_W; elaboration error otherwise.
- `CNT_W`, default 8: width of the frame-length field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `clear`  in  1  synchronous abort of the open frame and the output.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  unit accepts a pair this cycle.
- `a`, `b`  in  DATA_W  operands.
- `len`  in  CNT_W  products per frame. Sampled only on a frame's first accepted beat. `len = 0` is treated as 1.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  frame sum.
- `out_ovf`  out  1  the frame overflowed ACC_W (sticky per frame).
- `busy`  out  1  a frame is open or a beat is in the pipeline.

## Operation
- **Beat acceptance.** A beat is accepted when `in_valid & in_ready`.
- **Stage 1.** Register `prod = a*b` (2·DATA_W bits, zero-extended to ACC_W), its valid bit, and a `last` flag.
- **Stage 2.** Accumulate the product.
  - First beat of a frame: load `acc = prod`. Do not add the previous sum.
  - Other beats: `acc = acc + prod`.
- **Frame state machine.**
  - States: IDLE (no frame open) and ACCUM.
  - IDLE → ACCUM on an accepted beat when the latched length is > 1. The beat counter loads 1.
  - ACCUM: the counter increments per accepted beat.
  - When the counter reaches the latched length, that beat is tagged `last` and the state returns to IDLE.
  - A length-1 frame stays in IDLE and its beat is tagged `last`.
- **Final beat.**
  - At stage 2, the final sum is written to `out_acc`, and `out_ovf` gets the frame's sticky overflow bit.
  - `out_valid` is set.
  - The accumulator restarts, so back-to-back frames run with no bubble.
- **Overflow.** Overflow is a carry out of bit ACC_W-1 on any add. Without saturation the sum wraps modulo 2^ACC_W.
- **Stall.**
  - `stall = out_valid & ~out_ready`.
  - While stalled, stage 1, stage 2, the counter and the state hold, and `in_ready = 0`.
  - Otherwise `in_ready = ~clear & ~reset`.
- **Output handshake.**
  - `out_valid` drops on the edge where `out_ready` is 1, unless a new final beat lands on that same edge.
  - If it does, `out_valid` stays 1 with the new value.
- **Priority.**
  - `reset` > `clear` > normal operation.
  - `clear` has the same effect as `reset` on all state: the pipeline is flushed, the partial sum is discarded, `out_valid` is dropped and the state goes to IDLE.
  - A beat presented in a `clear` cycle is not accepted.
- **Busy.** `busy = (state == ACCUM) | stage1_valid | stage2_pending`.

## Timing
- **Reset values.** `out_valid = 0`, `out_acc = 0`, `out_ovf = 0`, `busy = 0`, `in_ready = 0` during reset, state IDLE, counter 0.
- **Latency.** The final beat is accepted at edge T. `out_valid` is high after edge T+2 when unstalled. Each stall cycle adds one.
- **Throughput.** One beat per cycle with no stall.
- **Output stability.** `out_acc` and `out_ovf` are stable while `out_valid & ~out_ready`.
- **`len` timing.** A change to `len` mid-frame has no effect.
- **Reset or clear mid-frame.** No result is emitted for the aborted frame. The first beat after deassertion starts a new frame.

## Configuration
- `MAC_SAT_EN` defined:
  - On overflow the accumulator clamps to 2^ACC_W−1 and stays clamped for the rest of the frame.
  - `out_ovf` is 1.
- `MAC_SAT_EN` undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - `out_ovf` is still reported.

## Test plan
- **Single-product frame.** DATA_W=16, ACC_W=40, `len=1`, a=10, b=20 → `out_acc=200`, `out_ovf=0`, `out_valid` 2 cycles after acceptance.
- **Back-to-back frames.**
  - Frame 1: `len=4`, pairs (1,2),(3,4),(5,6),(7,8) → 100.
  - Frame 2 starts the next cycle: `len=2`, pairs (10,20),(2,3) → 206.
  - No idle cycle between results; frame 1 shows no carry-in.
- **Backpressure.** `out_ready=0` for 5 cycles after 100 is presented → `out_acc` holds 100, `in_ready=0`, and no beat is lost. Results resume correctly after `out_ready=1`.
- **Overflow.** DATA_W=16, ACC_W=32, `len=2`, two beats of 65535×65535:
  - Without `MAC_SAT_EN`: `out_acc=4294705154`, `out_ovf=1`.
  - With `MAC_SAT_EN`: `out_acc=4294967295`, `out_ovf=1`.
- **Clear mid-frame.** `len=4`, `clear` pulsed after 2 beats → `busy=0`, no `out_valid`. Then `len=1`, 3×3 → `out_acc=9`.
- **Reset mid-frame with held output.** `reset` for 1 cycle while `out_valid=1` and a frame is in flight → all outputs 0 next cycle, `in_ready=1` after deassertion, and the next frame is correct.
